fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//   Read-side companion of the register FIFO: pops IN_W-bit words from a show-ahead FIFO
//   and serialises each word into RATIO output beats of OUT_W bits on a valid/ready stream.
//   Asserts o_tlast on every PKT_BEATS-th accepted beat to frame fixed-length packets.
//   Sits between the FIFO read port and a narrower downstream consumer.
// PARAMETERS
//   IN_W       32  FIFO word width; must equal RATIO*OUT_W
//   RATIO      4   output beats per FIFO word (>=1; 1 = width pass-through)
//   PKT_BEATS  16  accepted beats per packet (>=1); o_tlast on the last one
//   LSB_FIRST  1   1: slice [OUT_W-1:0] goes out first; 0: MS slice first
// PORTS
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-high
//   i_empty    in   1      FIFO empty flag
//   i_rddata   in   IN_W   FIFO head word; valid whenever i_empty=0
//   o_rden     out  1      FIFO pop strobe; head consumed at the clk edge where it is 1
//   o_tdata    out  OUT_W  stream data, OUT_W = IN_W/RATIO
//   o_tvalid   out  1      stream valid
//   i_tready   in   1      stream ready
//   o_tlast    out  1      last beat of packet (qualified by o_tvalid)
//   i_flush    in   1      drop the held word and restart packet framing
//   o_busy     out  1      1 while a word is held (o_tvalid)
// BEHAVIOUR
//   - State: word_rg[IN_W], sub_rg[clog2(RATIO)] slice index, hold_rg (word held),
//     beat_rg[clog2(PKT_BEATS)] packet beat counter.
//   - Reset (rst=1 at edge): hold_rg=0, sub_rg=0, beat_rg=0, word_rg=0. Outputs: o_tvalid=0,
//     o_tlast=0, o_busy=0, o_rden=0, o_tdata=0. Reset overrides all other inputs.
//   - accept = o_tvalid & i_tready; last_sub = (sub_rg==RATIO-1).
//   - o_rden = !i_empty & !i_flush & !rst & (!hold_rg | (accept & last_sub)). Combinational;
//     never 1 while i_empty=1.
//   - Pop edge: word_rg<=i_rddata, sub_rg<=0, hold_rg<=1.
//   - Accept with !last_sub: sub_rg<=sub_rg+1. Accept with last_sub and no pop: hold_rg<=0.
//     Accept with last_sub and pop in the same cycle: reload, no bubble.
//   - o_tvalid = hold_rg. o_tdata = slice sub_rg of word_rg (or RATIO-1-sub_rg if LSB_FIRST=0).
//   - Latency: first beat is valid in the cycle after the pop edge. Throughput: 1 beat/cycle
//     sustained while i_tready=1 and the FIFO stays non-empty.
//   - Stall: while o_tvalid=1 and i_tready=0, o_tdata/o_tlast/o_tvalid hold stable and no pop.
//   - Framing: each accept advances beat_rg, wrapping PKT_BEATS-1 -> 0.
//     o_tlast = o_tvalid & (beat_rg==PKT_BEATS-1). Framing is independent of word boundaries.
//     PKT_BEATS=1 gives o_tlast on every valid beat.
//   - i_flush=1 at edge: hold_rg<=0, sub_rg<=0, beat_rg<=0; no pop that cycle. o_tvalid may
//     be 1 in the flush cycle. An accept in that same cycle still counts as transferred
//     downstream, but the state is cleared regardless.
//   - Reset mid-word: remaining slices are discarded, FIFO contents untouched.
// TESTING
//   - Reset: rst=1 for 2 cycles with i_empty=0 -> o_rden=0, o_tvalid=0 and o_tlast=0 in every
//     reset cycle.
//   - Serialise: FIFO holds 0xDDCCBBAA, i_tready=1, OUT_W=8 -> one pop, then beats
//     AA,BB,CC,DD on 4 consecutive cycles.
//   - Back-to-back: 8 words queued, i_tready=1 -> 32 contiguous valid beats, pops on cycles
//     0,4,8,... with no bubble. o_tlast on beats 16 and 32.
//   - Backpressure: i_tready toggles 1,0,0,1 mid-word -> o_tdata stable while stalled, no
//     pop, no slice lost or duplicated.
//   - Empty boundary: FIFO runs dry after 1 word -> o_tvalid drops after DD; o_rden stays 0
//     until i_empty=0. Next word's first beat is valid one cycle after its pop.
//   - Flush: i_flush at sub_rg=2, beat_rg=6 -> o_tvalid=0 next cycle. Next word restarts at
//     its slice 0 with beat_rg=0; o_tlast lands after 16 new beats.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Bundles the show-ahead FIFO read port and the downstream valid/ready stream
// of the FIFO stream reader.
interface fifo_stream_reader_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
);
    logic             i_empty;
    logic [IN_W-1:0]  i_rddata;
    logic             o_rden;
    logic [OUT_W-1:0] o_tdata;
    logic             o_tvalid;
    logic             i_tready;
    logic             o_tlast;

    // Reader side: pops the FIFO and drives the stream.
    modport master (
        input  i_empty,
        input  i_rddata,
        output o_rden,
        output o_tdata,
        output o_tvalid,
        input  i_tready,
        output o_tlast
    );

    // Environment side: FIFO read port plus downstream consumer.
    modport slave (
        output i_empty,
        output i_rddata,
        input  o_rden,
        input  o_tdata,
        input  o_tvalid,
        output i_tready,
        input  o_tlast
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops words from a show-ahead FIFO and serialises each into RATIO narrower
// beats on a valid/ready stream, framing fixed-length packets with o_tlast.
module fifo_stream_reader #(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned PKT_BEATS = 16,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    output logic                 o_busy,
    fifo_stream_reader_if.master bus
);
    localparam int unsigned OUT_W  = IN_W / RATIO;
    localparam int unsigned SUB_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(RATIO - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_BEATS - 1);

    logic [IN_W-1:0]   word_rg;
    logic [SUB_W-1:0]  sub_rg;
    logic              hold_rg;
    logic [BEAT_W-1:0] beat_rg;

    logic              accept;
    logic              last_sub;
    logic              pop;
    logic [SUB_W-1:0]  slice_idx;
    logic [OUT_W-1:0]  slice_data;

    // Handshake decode; a pop is allowed when idle or when the last slice leaves.
    always_comb begin
        accept   = hold_rg & bus.i_tready;
        last_sub = (sub_rg == SUB_LAST);
        pop      = ~bus.i_empty & ~i_flush & ~rst & (~hold_rg | (accept & last_sub));
    end

    // Select the outgoing slice; MS-first order simply mirrors the index.
    always_comb begin
        slice_idx  = LSB_FIRST ? sub_rg : (SUB_LAST - sub_rg);
        slice_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (slice_idx == SUB_W'(i)) begin
                slice_data = word_rg[i*OUT_W +: OUT_W];
            end
        end
    end

    // Stream outputs are driven straight from the held-word state.
    always_comb begin
        bus.o_rden   = pop;
        bus.o_tvalid = hold_rg;
        bus.o_tdata  = slice_data;
        bus.o_tlast  = hold_rg & (beat_rg == BEAT_LAST);
        o_busy       = hold_rg;
    end

    // Word holding, slice stepping and packet framing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_rg <= '0;
            sub_rg  <= '0;
            hold_rg <= 1'b0;
            beat_rg <= '0;
        end else if (i_flush) begin
            // An accept in this cycle still went downstream, but framing restarts.
            sub_rg  <= '0;
            hold_rg <= 1'b0;
            beat_rg <= '0;
        end else begin
            if (accept) begin
                beat_rg <= (beat_rg == BEAT_LAST) ? '0 : beat_rg + 1'b1;
            end
            if (pop) begin
                word_rg <= bus.i_rddata;
                sub_rg  <= '0;
                hold_rg <= 1'b1;
            end else if (accept) begin
                if (last_sub) begin
                    sub_rg  <= '0;
                    hold_rg <= 1'b0;
                end else begin
                    sub_rg <= sub_rg + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader (IN_W=32, RATIO=4, PKT_BEATS=16,
// LSB first). The FIFO is a queue of words; expected output is the queue of
// byte slices of popped words, with packet framing counted in accepted beats.
module tb_fifo_stream_reader;
    localparam int unsigned PKT = 16;

    logic clk;
    logic rst;
    logic i_flush;
    logic o_busy;

    fifo_stream_reader_if #(.IN_W(32), .OUT_W(8)) bus ();

    fifo_stream_reader #(
        .IN_W      (32),
        .RATIO     (4),
        .PKT_BEATS (16),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_flush),
        .o_busy  (o_busy),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          beat_cnt;
    int          tlast_seen;
    int          acc_seen;
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int          pop_cyc[$];
    bit          prev_stall;
    logic [7:0]  prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.i_empty  = (fifo_q.size() == 0);
        bus.i_rddata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic cycle(input bit rdy, input bit fl);
        bit          e_valid;
        bit          e_acc;
        bit          e_rden;
        logic [31:0] w;
        bus.i_tready = rdy;
        i_flush      = fl;
        drive_fifo();
        #1;
        e_valid = (exp_q.size() != 0);
        e_acc   = e_valid & rdy;
        e_rden  = (fifo_q.size() != 0) & ~fl & (~e_valid | (e_acc & (exp_q.size() == 1)));
        chk("tvalid", 32'(bus.o_tvalid), 32'(e_valid));
        chk("busy", 32'(o_busy), 32'(e_valid));
        chk("rden", 32'(bus.o_rden), 32'(e_rden));
        chk("tlast", 32'(bus.o_tlast), 32'(e_valid && (beat_cnt % PKT == PKT - 1)));
        if (e_valid) chk("tdata", 32'(bus.o_tdata), 32'(exp_q[0]));
        if (prev_stall) chk("stall_hold", 32'(bus.o_tdata), 32'(prev_data));
        if (bus.o_tvalid && rdy && bus.o_tlast) tlast_seen++;
        if (bus.o_tvalid && rdy) acc_seen++;
        prev_stall = e_valid & ~rdy & ~fl;
        prev_data  = bus.o_tdata;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            beat_cnt = 0;
        end else begin
            if (e_acc) begin
                void'(exp_q.pop_front());
                beat_cnt++;
            end
            if (e_rden) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < 4; i++) exp_q.push_back(w[i*8 +: 8]);
                pop_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        beat_cnt     = 0;
        tlast_seen   = 0;
        acc_seen     = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        rst          = 1'b1;
        i_flush      = 1'b0;
        bus.i_tready = 1'b1;
        fifo_q.push_back(32'hDDCCBBAA);
        drive_fifo();

        // Reset with a non-empty FIFO: nothing popped, outputs quiet.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_rden", 32'(bus.o_rden), 32'd0);
            chk("rst_tvalid", 32'(bus.o_tvalid), 32'd0);
            chk("rst_tlast", 32'(bus.o_tlast), 32'd0);
            chk("rst_tdata", 32'(bus.o_tdata), 32'd0);
        end
        rst = 1'b0;

        // Serialise one word: AA, BB, CC, DD.
        pop_cyc.delete();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        chk("ser_pops", 32'(pop_cyc.size()), 32'd1);

        // Back-to-back: 8 words from fresh framing.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
        pop_cyc.delete();
        tlast_seen = 0;
        acc_seen   = 0;
        for (int i = 0; i < 34; i++) cycle(1'b1, 1'b0);
        chk("b2b_pops", 32'(pop_cyc.size()), 32'd8);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("b2b_pop_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd4);
        chk("b2b_beats", 32'(acc_seen), 32'd32);
        chk("b2b_tlast", 32'(tlast_seen), 32'd2);

        // Backpressure mid-word.
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

        // Empty boundary: run dry, idle, then a late word.
        fifo_q.push_back($urandom);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        fifo_q.push_back($urandom);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

        // Flush at slice 2 / beat 6, then framing restarts.
        cycle(1'b1, 1'b1);
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
        tlast_seen = 0;
        for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0);
        chk("flush_tlast", 32'(tlast_seen), 32'd1);

        // Randomised traffic, ready and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 9) < 4) fifo_q.push_back($urandom);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
